// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: ALU opcodes, EX-stage control bundle, register-zero index.
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;

  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode-side valid/ready handshake, forwarding sources and EX-stage outputs.
interface id_ex_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic [3:0]    id_alu_ctrl;
  logic          id_alu_src;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          id_mem_to_reg;
  logic          id_branch;
  logic          flush;
  logic          exmem_reg_write;
  logic [RW-1:0] exmem_rd;
  logic [DW-1:0] exmem_res;
  logic          memwb_reg_write;
  logic [RW-1:0] memwb_rd;
  logic [DW-1:0] memwb_data;
  logic          ex_valid;
  logic [DW-1:0] operand1;
  logic [DW-1:0] operand2;
  logic [3:0]    alu_ctrl;
  logic [DW-1:0] ex_store_data;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          ex_mem_to_reg;
  logic          ex_branch;
  logic          stall;

  modport slave (
    input  in_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_alu_ctrl, id_alu_src, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, id_branch, flush,
           exmem_reg_write, exmem_rd, exmem_res, memwb_reg_write, memwb_rd, memwb_data,
    output in_ready, ex_valid, operand1, operand2, alu_ctrl, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, stall
  );

  modport master (
    output in_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_alu_ctrl, id_alu_src, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, id_branch, flush,
           exmem_reg_write, exmem_rd, exmem_res, memwb_reg_write, memwb_rd, memwb_data,
    input  in_ready, ex_valid, operand1, operand2, alu_ctrl, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, stall
  );

endinterface

// File: rtl/fwd_sel.sv
// Operand forwarding mux: EX/MEM beats MEM/WB beats register file; r0 never forwarded.
// Purely combinational, no backpressure.
module fwd_sel
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] idx,
  input  logic [DW-1:0] rf_data,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_res,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_data,
  output logic [DW-1:0] data
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_reg_write && (exmem_rd != RW'(REG_ZERO)) && (exmem_rd == idx);
  assign memwb_hit = memwb_reg_write && (memwb_rd != RW'(REG_ZERO)) && (memwb_rd == idx);

  always_comb begin
    data = rf_data;
    if (exmem_hit) begin
      data = exmem_res;
    end else if (memwb_hit) begin
      data = memwb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding; one cycle accept-to-EX latency.
// Backpressure: in_ready drops for one cycle on a load-use hazard (bubble inserted); flush forces a bubble.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave bus
);

  logic          valid_q;
  ex_ctrl_t      ctrl_q;
  ex_ctrl_t      id_ctrl;
  logic [RW-1:0] rs_q;
  logic [RW-1:0] rt_q;
  logic [RW-1:0] rd_q;
  logic [DW-1:0] rs_data_q;
  logic [DW-1:0] rt_data_q;
  logic [DW-1:0] imm_q;
  logic [3:0]    alu_ctrl_q;
  logic          alu_src_q;
  logic          load_use;
  logic          rt_used;
  logic [DW-1:0] rs_fwd;
  logic [DW-1:0] rt_fwd;

  assign id_ctrl = '{reg_write:  bus.id_reg_write,
                     mem_read:   bus.id_mem_read,
                     mem_write:  bus.id_mem_write,
                     mem_to_reg: bus.id_mem_to_reg,
                     branch:     bus.id_branch};

  // rt only matters when it feeds the ALU or is the store data
  assign rt_used  = !bus.id_alu_src || bus.id_mem_write;
  assign load_use = valid_q && ctrl_q.mem_read && (rd_q != RW'(REG_ZERO)) && bus.in_valid &&
                    ((rd_q == bus.id_rs) || ((rd_q == bus.id_rt) && rt_used));

  assign bus.in_ready = bus.flush || !load_use;
  assign bus.stall    = !bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      ctrl_q     <= EX_CTRL_NOP;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      alu_ctrl_q <= ALU_AND;
      alu_src_q  <= 1'b0;
    end else if (bus.flush || load_use || !bus.in_valid) begin
      valid_q <= 1'b0;
      ctrl_q  <= EX_CTRL_NOP;
    end else begin
      valid_q    <= 1'b1;
      ctrl_q     <= id_ctrl;
      rs_q       <= bus.id_rs;
      rt_q       <= bus.id_rt;
      rd_q       <= bus.id_rd;
      rs_data_q  <= bus.id_rs_data;
      rt_data_q  <= bus.id_rt_data;
      imm_q      <= bus.id_imm;
      alu_ctrl_q <= bus.id_alu_ctrl;
      alu_src_q  <= bus.id_alu_src;
    end
  end

  fwd_sel #(.DW(DW), .RW(RW)) u_fwd_rs (
    .idx             (rs_q),
    .rf_data         (rs_data_q),
    .exmem_reg_write (bus.exmem_reg_write),
    .exmem_rd        (bus.exmem_rd),
    .exmem_res       (bus.exmem_res),
    .memwb_reg_write (bus.memwb_reg_write),
    .memwb_rd        (bus.memwb_rd),
    .memwb_data      (bus.memwb_data),
    .data            (rs_fwd)
  );

  fwd_sel #(.DW(DW), .RW(RW)) u_fwd_rt (
    .idx             (rt_q),
    .rf_data         (rt_data_q),
    .exmem_reg_write (bus.exmem_reg_write),
    .exmem_rd        (bus.exmem_rd),
    .exmem_res       (bus.exmem_res),
    .memwb_reg_write (bus.memwb_reg_write),
    .memwb_rd        (bus.memwb_rd),
    .memwb_data      (bus.memwb_data),
    .data            (rt_fwd)
  );

  assign bus.ex_valid      = valid_q;
  assign bus.operand1      = rs_fwd;
  assign bus.operand2      = alu_src_q ? imm_q : rt_fwd;
  assign bus.ex_store_data = rt_fwd;
  assign bus.alu_ctrl      = alu_ctrl_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_reg_write  = valid_q && ctrl_q.reg_write;
  assign bus.ex_mem_read   = valid_q && ctrl_q.mem_read;
  assign bus.ex_mem_write  = valid_q && ctrl_q.mem_write;
  assign bus.ex_mem_to_reg = valid_q && ctrl_q.mem_to_reg;
  assign bus.ex_branch     = valid_q && ctrl_q.branch;

endmodule
